// File: rtl/axi_pmp_read_gate.sv
// rtl/axi_pmp_read_gate.sv - AXI read-address PMP gate with SLVERR completion of denied bursts
//
// Accepts one AR at a time from the upstream slave port and holds it in a latch.
// The latched AR goes to the PMP checker. A permitted AR is forwarded downstream.
// For a denied AR, the gate waits until every forwarded read burst has returned its
// last beat, then answers the burst itself with SLVERR beats. AW, W and B pass
// straight through.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   slv_req_i / slv_rsp_o   upstream AXI slave port (request in, response out)
//   mst_req_o / mst_rsp_i   downstream AXI master port (request out, response in)
//   pmp_addr_o/len_o/size_o latched AR fields under check
//   pmp_valid_o             check request, high for the whole CHECK state
//   pmp_done_i/pmp_allow_i  check result; allow is sampled only with valid && done
//   denied_cnt_o            saturating count of denied ARs
//
// Optional feature macro: AXI_PMP_READ_GATE_DENY_CNT_EN
//   defined   -> denied_cnt_o is a 16-bit saturating deny counter
//   undefined -> no counter register, denied_cnt_o is tied to zero

package axi_pmp_read_gate_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       user;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;
endpackage

module axi_pmp_read_gate #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter type         axi_req_t       = axi_pmp_read_gate_pkg::axi_req_t,
    parameter type         axi_rsp_t       = axi_pmp_read_gate_pkg::axi_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  axi_req_t              slv_req_i,
    output axi_rsp_t              slv_rsp_o,
    output axi_req_t              mst_req_o,
    input  axi_rsp_t              mst_rsp_i,
    output logic [ADDR_WIDTH-1:0] pmp_addr_o,
    output logic [7:0]            pmp_len_o,
    output logic [2:0]            pmp_size_o,
    output logic                  pmp_valid_o,
    input  logic                  pmp_done_i,
    input  logic                  pmp_allow_i,
    output logic [15:0]           denied_cnt_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FWD,
        DRAIN,
        ERR
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [7:0]    beat_q, beat_d;
    axi_req_t      req_lat_q, req_lat_d;
    logic          ar_inc;
    logic          r_dec;

    // The PMP checker always sees the latch, so its inputs cannot change while
    // a check is pending.
    assign pmp_addr_o = ADDR_WIDTH'(req_lat_q.ar.addr);
    assign pmp_len_o  = req_lat_q.ar.len;
    assign pmp_size_o = req_lat_q.ar.size;

    always_comb begin
        state_d   = state_q;
        outst_d   = outst_q;
        beat_d    = beat_q;
        req_lat_d = req_lat_q;
        ar_inc    = 1'b0;

        // AW/W/B and the downstream R path are wires; AR is always sourced from the latch.
        mst_req_o          = slv_req_i;
        mst_req_o.ar       = req_lat_q.ar;
        mst_req_o.ar_valid = 1'b0;
        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.ar_ready = 1'b0;
        pmp_valid_o        = 1'b0;

        // Handshake outputs are qualified with rst_ni so they stay low while reset is held.
        unique case (state_q)
            IDLE: begin
                slv_rsp_o.ar_ready = rst_ni && (outst_q < MAX_OUT);
                if (slv_req_i.ar_valid && slv_rsp_o.ar_ready) begin
                    req_lat_d.ar = slv_req_i.ar;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                pmp_valid_o = rst_ni;
                if (pmp_done_i) begin
                    state_d = pmp_allow_i ? FWD : DRAIN;
                end
            end
            FWD: begin
                mst_req_o.ar_valid = rst_ni;
                if (mst_rsp_i.ar_ready) begin
                    ar_inc  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Earlier permitted bursts may share this ID, so the error
                // beats must come after all their data has returned.
                if (outst_q == '0) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                slv_rsp_o.r       = '0;
                slv_rsp_o.r.id    = ID_WIDTH'(req_lat_q.ar.id);
                slv_rsp_o.r.data  = DATA_WIDTH'(0);
                slv_rsp_o.r.resp  = 2'b10;
                slv_rsp_o.r.last  = (beat_q == req_lat_q.ar.len);
                slv_rsp_o.r_valid = rst_ni;
                mst_req_o.r_ready = 1'b0;
                if (slv_req_i.r_ready) begin
                    // Comparing with len before incrementing lets len=255 produce
                    // all 256 beats without the 8-bit counter wrapping.
                    if (slv_rsp_o.r.last) begin
                        beat_d  = 8'd0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        r_dec = mst_rsp_i.r_valid && mst_req_o.r_ready && mst_rsp_i.r.last && (outst_q != '0);

        unique case ({ar_inc, r_dec})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            outst_q   <= '0;
            beat_q    <= '0;
            req_lat_q <= '0;
        end else begin
            state_q   <= state_d;
            outst_q   <= outst_d;
            beat_q    <= beat_d;
            req_lat_q <= req_lat_d;
        end
    end

`ifdef AXI_PMP_READ_GATE_DENY_CNT_EN
    logic [15:0] deny_cnt_q, deny_cnt_d;
    logic        deny_evt;

    assign deny_evt = (state_q == CHECK) && pmp_done_i && !pmp_allow_i;

    always_comb begin
        deny_cnt_d = deny_cnt_q;
        if (deny_evt && (deny_cnt_q != 16'hFFFF)) begin
            deny_cnt_d = deny_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            deny_cnt_q <= '0;
        end else begin
            deny_cnt_q <= deny_cnt_d;
        end
    end

    assign denied_cnt_o = deny_cnt_q;
`else
    assign denied_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_pmp_read_gate.sv
// tb/tb_axi_pmp_read_gate.sv - scoreboard bench for axi_pmp_read_gate
module tb_axi_pmp_read_gate;
    import axi_pmp_read_gate_pkg::*;

`ifdef AXI_PMP_READ_GATE_DENY_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_ni;
    axi_req_t    slv_req;
    axi_rsp_t    slv_rsp;
    axi_req_t    mst_req;
    axi_rsp_t    mst_rsp;
    logic [63:0] pmp_addr;
    logic [7:0]  pmp_len;
    logic [2:0]  pmp_size;
    logic        pmp_valid;
    logic        pmp_done;
    logic        pmp_allow;
    logic [15:0] denied_cnt;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_r_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
    } exp_ar_t;

    exp_r_t  exp_r_q[$];
    exp_ar_t exp_ar_q[$];
    int      n_tests = 0;
    int      n_fail = 0;
    int      r_beats = 0;
    bit      forbid_ar = 1'b0;

    axi_pmp_read_gate #(
        .axi_req_t(axi_req_t),
        .axi_rsp_t(axi_rsp_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .slv_req_i   (slv_req),
        .slv_rsp_o   (slv_rsp),
        .mst_req_o   (mst_req),
        .mst_rsp_i   (mst_rsp),
        .pmp_addr_o  (pmp_addr),
        .pmp_len_o   (pmp_len),
        .pmp_size_o  (pmp_size),
        .pmp_valid_o (pmp_valid),
        .pmp_done_i  (pmp_done),
        .pmp_allow_i (pmp_allow),
        .denied_cnt_o(denied_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard monitor: compares every upstream R beat and every downstream AR handshake.
    always @(negedge clk) begin
        if (slv_rsp.r_valid && slv_req.r_ready) begin
            if (exp_r_q.size() == 0) begin
                bound_fail("r_unexpected_beat");
            end else begin
                exp_r_t e;
                e = exp_r_q.pop_front();
                check("r_id", slv_rsp.r.id, e.id);
                check("r_data", slv_rsp.r.data, e.data);
                check("r_resp", slv_rsp.r.resp, e.resp);
                check("r_last", slv_rsp.r.last, e.last);
                r_beats++;
            end
        end
        if (mst_req.ar_valid && mst_rsp.ar_ready) begin
            if (exp_ar_q.size() == 0) begin
                bound_fail("ar_unexpected_fwd");
            end else begin
                exp_ar_t a;
                a = exp_ar_q.pop_front();
                check("mst_ar_id", mst_req.ar.id, a.id);
                check("mst_ar_addr", mst_req.ar.addr, a.addr);
                check("mst_ar_len", mst_req.ar.len, a.len);
            end
        end
        if (forbid_ar) check("no_mst_ar_valid", mst_req.ar_valid, 1'b0);
    end

    task automatic push_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                          input logic last);
        exp_r_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        exp_r_q.push_back(e);
    endtask

    task automatic push_err(input logic [3:0] id, input int len);
        for (int i = 0; i <= len; i++) push_r(id, 64'h0, 2'b10, (i == len));
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
        bit ok;
        slv_req.ar.id = id;
        slv_req.ar.addr = addr;
        slv_req.ar.len = len;
        slv_req.ar.size = 3'd3;
        slv_req.ar_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (slv_rsp.ar_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("ar_accept");
        @(posedge clk);
        #1 slv_req.ar_valid = 1'b0;
    endtask

    task automatic pmp_resp(input int delay, input logic allow, input logic [63:0] addr,
                            input logic [7:0] len);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("pmp_valid_hold", pmp_valid, 1'b1);
            check("pmp_addr_hold", pmp_addr, addr);
            check("pmp_len_hold", pmp_len, len);
            check("pmp_size_hold", pmp_size, 3'd3);
            @(posedge clk);
            #1;
        end
        pmp_done = 1'b1;
        pmp_allow = allow;
        @(negedge clk);
        check("pmp_valid", pmp_valid, 1'b1);
        check("pmp_addr", pmp_addr, addr);
        @(posedge clk);
        #1;
        pmp_done = 1'b0;
        pmp_allow = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input int delay, input logic allow);
        exp_ar_t a;
        if (allow) begin
            a.id = id; a.addr = addr; a.len = len;
            exp_ar_q.push_back(a);
        end else begin
            push_err(id, int'(len));
        end
        drive_ar(id, addr, len);
        pmp_resp(delay, allow, addr, len);
    endtask

    task automatic mst_beat(input logic [3:0] id, input logic [63:0] data);
        bit ok;
        mst_rsp.r.id = id;
        mst_rsp.r.data = data;
        mst_rsp.r.resp = 2'b00;
        mst_rsp.r.last = 1'b1;
        mst_rsp.r_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mst_req.r_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("mst_r_accept");
        @(posedge clk);
        #1 mst_rsp.r_valid = 1'b0;
    endtask

    task automatic wait_r_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_r_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("r_drain");
        #1;
    endtask

    initial begin
        int base;
        bit ok;
        slv_req = '0;
        mst_rsp = '0;
        mst_rsp.ar_ready = 1'b1;
        pmp_done = 1'b0;
        pmp_allow = 1'b0;
        rst_ni = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ar_ready", slv_rsp.ar_ready, 1'b0);
        check("rst_mst_ar_valid", mst_req.ar_valid, 1'b0);
        check("rst_pmp_valid", pmp_valid, 1'b0);
        check("rst_r_valid", slv_rsp.r_valid, 1'b0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("idle_ar_ready", slv_rsp.ar_ready, 1'b1);
        check("rst_denied_cnt", denied_cnt, 16'd0);

        // AW/W/B pass-through
        @(posedge clk);
        #1;
        slv_req.aw.addr = 64'h55;
        slv_req.aw_valid = 1'b1;
        mst_rsp.b_valid = 1'b1;
        #1;
        check("aw_addr_pass", mst_req.aw.addr, 64'h55);
        check("aw_valid_pass", mst_req.aw_valid, 1'b1);
        check("b_valid_pass", slv_rsp.b_valid, 1'b1);
        slv_req.aw_valid = 1'b0;
        mst_rsp.b_valid = 1'b0;
        @(posedge clk);
        #1;

        // Allowed single read, downstream AR back-pressured for two cycles
        slv_req.r_ready = 1'b1;
        mst_rsp.ar_ready = 1'b0;
        do_read(4'd3, 64'h1000, 8'd0, 0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("fwd_ar_valid_hold", mst_req.ar_valid, 1'b1);
            check("fwd_ar_addr_hold", mst_req.ar.addr, 64'h1000);
        end
        @(posedge clk);
        #1 mst_rsp.ar_ready = 1'b1;
        @(posedge clk);
        #1;
        push_r(4'd3, 64'hAB, 2'b00, 1'b1);
        mst_beat(4'd3, 64'hAB);
        wait_r_done(20);
        check("outst_after_single", dut.outst_q, 0);

        // Denied 4-beat burst
        forbid_ar = 1'b1;
        do_read(4'd5, 64'h2000, 8'd3, 0, 1'b0);
        wait_r_done(50);
        forbid_ar = 1'b0;
        check("denied_cnt_1", denied_cnt, CNT_EN ? 16'd1 : 16'd0);

        // Drain ordering: SLVERR must wait for both forwarded bursts
        do_read(4'd1, 64'h3000, 8'd0, 0, 1'b1);
        do_read(4'd2, 64'h3100, 8'd0, 0, 1'b1);
        push_r(4'd1, 64'h11, 2'b00, 1'b1);
        push_r(4'd2, 64'h22, 2'b00, 1'b1);
        do_read(4'd6, 64'h3200, 8'd1, 0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("drain_no_early_err", exp_r_q.size(), 4);
        mst_beat(4'd1, 64'h11);
        mst_beat(4'd2, 64'h22);
        wait_r_done(50);
        check("denied_cnt_2", denied_cnt, CNT_EN ? 16'd2 : 16'd0);

        // Outstanding limit and delayed PMP done
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i), 64'h4000 + 64'(i * 64), 8'd0, 0, 1'b1);
        end
        @(posedge clk);
        #1;
        check("outst_full", dut.outst_q, 4);
        slv_req.ar.id = 4'd4;
        slv_req.ar.addr = 64'h5000;
        slv_req.ar.len = 8'd0;
        slv_req.ar_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("limit_ar_ready_low", slv_rsp.ar_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        push_r(4'd0, 64'h100, 2'b00, 1'b1);
        mst_beat(4'd0, 64'h100);
        do_read(4'd4, 64'h5000, 8'd0, 5, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 1; i < 5; i++) begin
            push_r(4'(i), 64'h100 + 64'(i), 2'b00, 1'b1);
            mst_beat(4'(i), 64'h100 + 64'(i));
        end
        wait_r_done(50);
        check("outst_after_limit", dut.outst_q, 0);

        // 256-beat denied burst with random upstream stalls
        forbid_ar = 1'b1;
        base = r_beats;
        do_read(4'd7, 64'h6000, 8'd255, 0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_r_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            #1 slv_req.r_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) bound_fail("long_burst_drain");
        #1 slv_req.r_ready = 1'b1;
        forbid_ar = 1'b0;
        check("long_burst_beats", r_beats - base, 256);
        check("denied_cnt_3", denied_cnt, CNT_EN ? 16'd3 : 16'd0);

        // Reset in the middle of an error burst (after two of four beats)
        base = r_beats;
        do_read(4'd9, 64'h7000, 8'd3, 0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (r_beats - base >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("mid_err_beats");
        #1;
        slv_req.r_ready = 1'b0;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        exp_r_q.delete();
        @(negedge clk);
        check("post_rst_r_valid", slv_rsp.r_valid, 1'b0);
        check("post_rst_ar_ready", slv_rsp.ar_ready, 1'b1);
        check("post_rst_outst", dut.outst_q, 0);
        check("post_rst_denied_cnt", denied_cnt, 16'd0);

        // Recovery: a normal allowed read after reset
        @(posedge clk);
        #1 slv_req.r_ready = 1'b1;
        do_read(4'd8, 64'h8000, 8'd0, 1, 1'b1);
        @(posedge clk);
        #1;
        push_r(4'd8, 64'hCD, 2'b00, 1'b1);
        mst_beat(4'd8, 64'hCD);
        wait_r_done(20);

        repeat (3) @(posedge clk);
        check("exp_ar_empty", exp_ar_q.size(), 0);
        check("exp_r_empty", exp_r_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
